vga_timing_core: RTL and testbench

//   Parametrised raster timing generator: the next generation of the fixed
//   640x480@60 sync generator.

---
 rtl/vga_timing_core.sv | 117 +++++++++++
 tb/tb_vga_timing_core.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_core.sv
// Parametrised raster timing generator.
// Two wrap counters (h, v) advance on pix_en ticks. Every flag is decoded
// from the next-count values, so each flag registers together with the
// coordinate it describes. There is no skew between flags and coordinates.
module vga_timing_core #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CW       = 10,
    parameter int FW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    output logic          vga_h_sync,
    output logic          vga_v_sync,
    output logic          inDisplayArea,
    output logic          hblank,
    output logic          vblank,
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic          line_start,
    output logic          frame_start,
    output logic [FW-1:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Boundaries are held in CW+1 bits, so a total of exactly 2**CW still fits.
    localparam logic [CW:0] H_LAST     = (CW+1)'(H_TOTAL - 1);
    localparam logic [CW:0] V_LAST     = (CW+1)'(V_TOTAL - 1);
    localparam logic [CW:0] H_ACT      = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] V_ACT      = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] HS_START   = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] HS_END     = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] VS_START   = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] VS_END     = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic          h_wrap;
    logic          v_wrap;
    logic [CW-1:0] h_next;
    logic [CW-1:0] v_next;
    logic          hblank_next;
    logic          vblank_next;
    logic          hsync_act_next;
    logic          vsync_act_next;

    // Next coordinates and the flags that describe them.
    always_comb begin
        h_wrap         = ({1'b0, h_count} == H_LAST);
        v_wrap         = ({1'b0, v_count} == V_LAST);
        h_next         = h_wrap ? '0 : h_count + CW'(1);
        v_next         = v_count;
        if (h_wrap) begin
            v_next     = v_wrap ? '0 : v_count + CW'(1);
        end
        hblank_next    = ({1'b0, h_next} >= H_ACT);
        vblank_next    = ({1'b0, v_next} >= V_ACT);
        hsync_act_next = ({1'b0, h_next} >= HS_START) && ({1'b0, h_next} < HS_END);
        vsync_act_next = ({1'b0, v_next} >= VS_START) && ({1'b0, v_next} < VS_END);
    end

    // Counters and frame count. On reset the counters park on the last pixel,
    // so the first tick lands on (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_count     <= CW'(H_TOTAL - 1);
            v_count     <= CW'(V_TOTAL - 1);
            frame_count <= '0;
        end else if (pix_en) begin
            h_count <= h_next;
            v_count <= v_next;
            if (h_wrap && v_wrap) begin
                frame_count <= frame_count + FW'(1);
            end
        end
    end

    // Registered level flags decoded from the next coordinates.
    // These flags hold their value while pix_en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_h_sync    <= ~H_POL;
            vga_v_sync    <= ~V_POL;
            inDisplayArea <= 1'b0;
            hblank        <= 1'b1;
            vblank        <= 1'b1;
        end else if (pix_en) begin
            vga_h_sync    <= hsync_act_next ? H_POL : ~H_POL;
            vga_v_sync    <= vsync_act_next ? V_POL : ~V_POL;
            inDisplayArea <= ~hblank_next & ~vblank_next;
            hblank        <= hblank_next;
            vblank        <= vblank_next;
        end
    end

    // One-clk strobes. Each strobe is high only after the tick that wraps
    // the counter, and is low on every other clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= pix_en & h_wrap;
            frame_start <= pix_en & h_wrap & v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_core.sv
// Testbench for vga_timing_core.
// The bench runs two instances side by side: the default 640x480 mode, and
// a 7x6 mode with positive sync polarity and a 3-bit frame count.
// The reference model counts pix_en ticks since reset. From that count it
// derives the position in the raster with plain arithmetic.
module tb_vga_timing_core;

    logic clk = 1'b0;
    logic rst;
    logic pix_en;

    always #5 clk = ~clk;

    logic       d_hs, d_vs, d_de, d_hb, d_vb, d_ls, d_fs;
    logic [9:0] d_h, d_v;
    logic [7:0] d_fc;

    logic       s_hs, s_vs, s_de, s_hb, s_vb, s_ls, s_fs;
    logic [2:0] s_h, s_v;
    logic [2:0] s_fc;

    vga_timing_core dut_def (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .vga_h_sync(d_hs), .vga_v_sync(d_vs), .inDisplayArea(d_de),
        .hblank(d_hb), .vblank(d_vb), .h_count(d_h), .v_count(d_v),
        .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
    );

    vga_timing_core #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .CW(3), .FW(3)
    ) dut_small (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .vga_h_sync(s_hs), .vga_v_sync(s_vs), .inDisplayArea(s_de),
        .hblank(s_hb), .vblank(s_vb), .h_count(s_h), .v_count(s_v),
        .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: the tick count since reset, and whether the latest edge was a tick.
    int ticks     = 0;
    bit last_tick = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ticks     <= 0;
            last_tick <= 1'b0;
        end else begin
            if (pix_en) ticks <= ticks + 1;
            last_tick <= pix_en;
        end
    end

    typedef struct {
        int h, v, hs, vs, de, hb, vb, ls, fs, fc;
    } exp_t;

    function automatic exp_t model(int n, bit lt, int ha, int hf, int hsw, int hb,
                                   int va, int vf, int vsw, int vb, bit hp, bit vp, int fw);
        exp_t e;
        int ht = ha + hf + hsw + hb;
        int vt = va + vf + vsw + vb;
        int t  = ht * vt;
        int p;
        if (n == 0) begin
            e.h = ht - 1; e.v = vt - 1;
            e.hs = int'(!hp); e.vs = int'(!vp);
            e.de = 0; e.hb = 1; e.vb = 1; e.ls = 0; e.fs = 0; e.fc = 0;
        end else begin
            p    = (n - 1) % t;
            e.h  = p % ht;
            e.v  = p / ht;
            e.hb = int'(e.h >= ha);
            e.vb = int'(e.v >= va);
            e.de = int'(e.hb == 0 && e.vb == 0);
            e.hs = (e.h >= ha + hf && e.h < ha + hf + hsw) ? int'(hp) : int'(!hp);
            e.vs = (e.v >= va + vf && e.v < va + vf + vsw) ? int'(vp) : int'(!vp);
            e.ls = int'(lt && e.h == 0);
            e.fs = int'(lt && e.h == 0 && e.v == 0);
            e.fc = ((n - 1) / t + 1) % (1 << fw);
        end
        return e;
    endfunction

    task automatic check_all();
        exp_t e;
        e = model(ticks, last_tick, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 8);
        chk("def_h", d_h, e.h);     chk("def_v", d_v, e.v);
        chk("def_hs", d_hs, e.hs);  chk("def_vs", d_vs, e.vs);
        chk("def_de", d_de, e.de);  chk("def_hb", d_hb, e.hb);
        chk("def_vb", d_vb, e.vb);  chk("def_ls", d_ls, e.ls);
        chk("def_fs", d_fs, e.fs);  chk("def_fc", d_fc, e.fc);
        e = model(ticks, last_tick, 4, 1, 1, 1, 3, 1, 1, 1, 1'b1, 1'b1, 3);
        chk("sm_h", s_h, e.h);      chk("sm_v", s_v, e.v);
        chk("sm_hs", s_hs, e.hs);   chk("sm_vs", s_vs, e.vs);
        chk("sm_de", s_de, e.de);   chk("sm_hb", s_hb, e.hb);
        chk("sm_vb", s_vb, e.vb);   chk("sm_ls", s_ls, e.ls);
        chk("sm_fs", s_fs, e.fs);   chk("sm_fc", s_fc, e.fc);
    endtask

    // Compare the outputs against the model on every falling edge. The outputs are stable then.
    always @(negedge clk) check_all();

    initial begin
        int first_ls;
        int second_ls;
        int guard;
        rst    = 1'b0;
        pix_en = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("lit_rst_h", d_h, 799);
        chk("lit_rst_v", d_v, 524);
        chk("lit_rst_hs", d_hs, 1);
        chk("lit_rst_sm_hs", s_hs, 0);
        chk("lit_rst_fc", d_fc, 0);

        // Continuous ticks: check pinned values at known tick counts.
        pix_en = 1'b1;
        rst    = 1'b0;
        first_ls  = -1;
        second_ls = -1;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                chk("lit_first_h", d_h, 0);
                chk("lit_first_v", d_v, 0);
                chk("lit_first_fs", d_fs, 1);
                chk("lit_first_ls", d_ls, 1);
                chk("lit_first_de", d_de, 1);
                chk("lit_first_fc", d_fc, 1);
            end
            if (c == 640) chk("lit_de_h639", d_de, 1);
            if (c == 641) chk("lit_de_h640", d_de, 0);
            if (c == 656) chk("lit_hs_h655", d_hs, 1);
            if (c == 657) chk("lit_hs_h656", d_hs, 0);
            if (c == 752) chk("lit_hs_h751", d_hs, 0);
            if (c == 753) chk("lit_hs_h752", d_hs, 1);
            if (c == 5)   chk("lit_sm_hs_h4", s_hs, 0);
            if (c == 6)   chk("lit_sm_hs_h5", s_hs, 1);
            if (c == 29)  chk("lit_sm_vs_v4", s_vs, 1);
            if (c == 43)  chk("lit_sm_fs", s_fs, 1);
            if (c == 43)  chk("lit_sm_fc", s_fc, 2);
            if (d_ls && first_ls < 0) first_ls = c;
            else if (d_ls && second_ls < 0) second_ls = c;
        end
        chk("lit_line_period", second_ls - first_ls, 800);

        // Random ticks.
        repeat (6000) begin
            @(negedge clk);
            pix_en = ($urandom_range(0, 3) != 0);
        end

        // Alternating ticks: each line takes twice as many clks.
        first_ls  = -1;
        second_ls = -1;
        for (int c = 0; c < 3400; c++) begin
            @(negedge clk);
            if (d_ls && first_ls < 0) first_ls = c;
            else if (d_ls && second_ls < 0) second_ls = c;
            pix_en = ~pix_en;
        end
        chk("lit_line_period_half", second_ls - first_ls, 1600);

        // Reset asserted between clock edges in the middle of a line.
        @(negedge clk);
        pix_en = 1'b1;
        guard  = 0;
        while (d_h != 10'd300 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("wait_h300", d_h, 300);
        #2 rst = 1'b1;
        #1;
        chk("lit_arst_h", d_h, 799);
        chk("lit_arst_v", d_v, 524);
        chk("lit_arst_de", d_de, 0);
        chk("lit_arst_hs", d_hs, 1);
        chk("lit_arst_sm_h", s_h, 6);
        check_all();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("lit_rel_h", d_h, 0);
        chk("lit_rel_fs", d_fs, 1);
        chk("lit_rel_fc", d_fc, 1);
        repeat (500) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
